// File: rtl/kf_pkg.sv
// kf_pkg: widths, ADC frame geometry and FSM states shared by the measurement front end and kalman_filter
package kf_pkg;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 16;
  localparam int CODE_W    = 12;
  localparam int GAIN_W    = 20;

  typedef enum logic [1:0] {IDLE, CONV, SCALE, DONE} kf_state_e;

  // A 12-bit code times a 20-bit gain always fits in 32 bits, so nothing is lost.
  function automatic logic [DATA_W-1:0] scale(input logic [CODE_W-1:0] code, input logic [GAIN_W-1:0] gain);
    return DATA_W'(code) * DATA_W'(gain);
  endfunction
endpackage

// File: rtl/kf_meas_frontend_if.sv
// kf_meas_frontend_if: control, ADC serial and filter-facing signals of the measurement front end
interface kf_meas_frontend_if;
  import kf_pkg::*;
  logic              i_enable;
  logic [DATA_W-1:0] i_duty;
  logic              i_adc_miso;
  logic              o_adc_cs_n;
  logic              o_adc_sclk;
  logic [DATA_W-1:0] o_u;
  logic [DATA_W-1:0] o_y;
  logic              o_begin;
  logic              o_overrun;

  modport master (
    output i_enable, i_duty, i_adc_miso,
    input  o_adc_cs_n, o_adc_sclk, o_u, o_y, o_begin, o_overrun
  );

  modport slave (
    input  i_enable, i_duty, i_adc_miso,
    output o_adc_cs_n, o_adc_sclk, o_u, o_y, o_begin, o_overrun
  );
endinterface

// File: rtl/kf_meas_frontend_adc_spi_rx.sv
// adc_spi_rx: one-frame SPI read of the ADC (one cs-to-sclk setup cycle, 16 SCLK periods, MSB first)
module adc_spi_rx
  import kf_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk,
  output logic              done,
  output logic [CODE_W-1:0] code
);
  localparam int HW = $clog2(2 * FRAME_LEN);
  localparam logic [7:0]    CNT_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * FRAME_LEN - 1);

  logic          setup;
  logic [7:0]    cnt;
  logic [HW-1:0] half;

  // Last cycle of the final high half-period; the frame ends on the next edge.
  assign done = !cs_n && !setup && cnt == CNT_LAST && half == HALF_LAST;

  // Half-periods alternate low/high; a low-to-high change shifts MISO in, and the
  // 12-bit register lets the four leading zeros fall off the top.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_n  <= 1'b1;
      sclk  <= 1'b1;
      setup <= 1'b0;
      cnt   <= '0;
      half  <= '0;
      code  <= '0;
    end else if (cs_n) begin
      if (start) begin
        cs_n  <= 1'b0;
        setup <= 1'b1;
      end
    end else if (setup) begin
      setup <= 1'b0;
      sclk  <= 1'b0;
      cnt   <= '0;
      half  <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
      if (half == HALF_LAST) cs_n <= 1'b1;
      else begin
        half <= half + HW'(1);
        sclk <= ~sclk;
        if (!sclk) code <= {code[CODE_W-2:0], miso};
      end
    end
endmodule

// File: rtl/kf_meas_frontend.sv
// kf_meas_frontend: periodic ADC sampling, gain scaling and one-cycle begin strobe for kalman_filter
module kf_meas_frontend
  import kf_pkg::*;
#(
  parameter int                SAMPLE_DIV = 1000,
  parameter int                SCLK_DIV   = 2,
  parameter logic [GAIN_W-1:0] GAIN       = 20'd1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  kf_meas_frontend_if.slave bus
);
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam logic [TW-1:0] LAST = TW'(SAMPLE_DIV - 1);

  kf_state_e         state;
  logic [TW-1:0]     timer;
  logic              tick;
  logic              done;
  logic [DATA_W-1:0] hold;
  logic [CODE_W-1:0] code;

  adc_spi_rx #(.SCLK_DIV(SCLK_DIV)) u_rx (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .start(state == IDLE && tick),
    .miso (bus.i_adc_miso),
    .cs_n (bus.o_adc_cs_n),
    .sclk (bus.o_adc_sclk),
    .done (done),
    .code (code)
  );

  // Sample timer; tick is high for the cycle in which the timer has just wrapped to 0.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= bus.i_enable && timer == LAST;
      timer <= (!bus.i_enable || timer == LAST) ? '0 : timer + 1'b1;
    end

  // Conversion sequencer; results update only when leaving SCALE so they are stable under o_begin.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      bus.o_u       <= '0;
      bus.o_y       <= '0;
      bus.o_begin   <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      if (tick && state != IDLE) bus.o_overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          hold  <= bus.i_duty;
          state <= CONV;
        end
        CONV: if (done) state <= SCALE;
        SCALE: begin
          bus.o_y     <= scale(code, GAIN);
          bus.o_u     <= hold;
          bus.o_begin <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          bus.o_begin <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_kf_meas_frontend.sv
// tb_kf_meas_frontend: scoreboard bench over three parameterisations of the front end
module tb_kf_meas_frontend;
  typedef struct {
    int          id;
    logic [31:0] u;
    logic [31:0] y;
    int          cyc;
  } exp_t;

  localparam logic [31:0] DUTY [5] = '{32'h0000_8000, 32'h0000_1234, 32'h00FF_0000, 32'hFFFF_FFFF, 32'h0000_0001};
  localparam logic [15:0] FRAME[5] = '{16'h0ABC, 16'hF555, 16'h0000, 16'h0FFF, 16'h0800};
  localparam logic [31:0] YEXP [5] = '{32'h0000_0ABC, 32'h0000_0555, 32'h0000_0000, 32'h0000_0FFF, 32'h0000_0800};

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_bc = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [15:0] frame_a = '0, frame_b = '0, frame_c = '0;
  int idx_a = 0, idx_b = 0, idx_c = 0, rises_a = 0;
  logic prev_a = 1'b1, prev_b = 1'b1, prev_c = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kf_meas_frontend_if bus_a ();
  kf_meas_frontend_if bus_b ();
  kf_meas_frontend_if bus_c ();

  kf_meas_frontend #(.SAMPLE_DIV(200), .SCLK_DIV(2), .GAIN(20'd1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .bus(bus_a));
  kf_meas_frontend #(.SAMPLE_DIV(200), .SCLK_DIV(2), .GAIN(20'hFFFFF)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n_bc), .bus(bus_b));
  kf_meas_frontend #(.SAMPLE_DIV(200), .SCLK_DIV(7), .GAIN(20'd1)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n_bc), .bus(bus_c));

  // ADC models: present frame bit (15 - rises seen) until the next SCLK rise.
  always @(negedge clk) begin
    if (bus_a.o_adc_cs_n) idx_a <= 0;
    else if (bus_a.o_adc_sclk && !prev_a) begin
      idx_a   <= idx_a + 1;
      rises_a <= rises_a + 1;
    end
    prev_a <= bus_a.o_adc_sclk;
  end
  always @(negedge clk) begin
    if (bus_b.o_adc_cs_n) idx_b <= 0;
    else if (bus_b.o_adc_sclk && !prev_b) idx_b <= idx_b + 1;
    prev_b <= bus_b.o_adc_sclk;
  end
  always @(negedge clk) begin
    if (bus_c.o_adc_cs_n) idx_c <= 0;
    else if (bus_c.o_adc_sclk && !prev_c) idx_c <= idx_c + 1;
    prev_c <= bus_c.o_adc_sclk;
  end
  assign bus_a.i_adc_miso = idx_a < 16 ? frame_a[4'(15 - idx_a)] : 1'b0;
  assign bus_b.i_adc_miso = idx_b < 16 ? frame_b[4'(15 - idx_b)] : 1'b0;
  assign bus_c.i_adc_miso = idx_c < 16 ? frame_c[4'(15 - idx_c)] : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [31:0] u, input logic [31:0] y, input int c);
    exp_t e;
    e.id = id;
    e.u = u;
    e.y = y;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic pop(input int id, input logic [31:0] u, input logic [31:0] y);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_begin inst %0d got o_begin=1 want 0 at cycle %0d", id, cyc);
    end else begin
      e = sb.pop_front();
      chk("begin_inst", id, e.id);
      chk("o_u", u, e.u);
      chk("o_y", y, e.y);
      chk("begin_cycle", cyc, e.cyc);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus_a.o_begin) pop(0, bus_a.o_u, bus_a.o_y);
      if (bus_b.o_begin) pop(1, bus_b.o_u, bus_b.o_y);
      if (bus_c.o_begin) pop(2, bus_c.o_u, bus_c.o_y);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_cs_n"}, 32'(bus_a.o_adc_cs_n), 1);
    chk({tag, "_sclk"}, 32'(bus_a.o_adc_sclk), 1);
    chk({tag, "_u"}, bus_a.o_u, 0);
    chk({tag, "_y"}, bus_a.o_y, 0);
    chk({tag, "_begin"}, 32'(bus_a.o_begin), 0);
    chk({tag, "_overrun"}, 32'(bus_a.o_overrun), 0);
  endtask

  initial begin
    int c0, c1, c2, c3, r0, base;
    bus_a.i_enable = 1'b0; bus_b.i_enable = 1'b0; bus_c.i_enable = 1'b0;
    bus_a.i_duty = '0;     bus_b.i_duty = '0;     bus_c.i_duty = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk_reset_a("reset");
    rst_n_a = 1'b1;
    rst_n_bc = 1'b1;
    repeat (2) @(negedge clk);

    c0 = cyc;
    bus_a.i_duty = DUTY[0];
    frame_a = FRAME[0];
    bus_a.i_enable = 1'b1;
    for (int k = 0; k < 5; k++) push(0, DUTY[k], YEXP[k], c0 + 200 * (k + 1) + 67);
    for (int k = 0; k < 4; k++) begin
      wait_to(c0 + 200 * (k + 1) + 30);
      bus_a.i_duty = DUTY[k + 1];
      wait_to(c0 + 200 * (k + 1) + 100);
      frame_a = FRAME[k + 1];
    end
    wait_to(c0 + 1020);
    bus_a.i_enable = 1'b0;
    wait_to(c0 + 1150);
    chk("sclk_rises", rises_a, 80);
    chk("overrun_a", 32'(bus_a.o_overrun), 0);
    chk("pending_a", sb.size(), 0);

    c1 = cyc;
    bus_a.i_duty = 32'hCAFE_F00D;
    frame_a = 16'h0321;
    bus_a.i_enable = 1'b1;
    push(0, 32'hCAFE_F00D, 32'h0000_0321, c1 + 267);
    wait_to(c1 + 300);
    base = rises_a;
    for (int i = 0; i < 400 && rises_a != base + 8; i++) @(negedge clk);
    chk("rise8_reached", rises_a, base + 8);
    chk("midframe_cs_n", 32'(bus_a.o_adc_cs_n), 0);
    #1 rst_n_a = 1'b0;
    #1 chk_reset_a("async_reset");
    @(negedge clk);
    rst_n_a = 1'b1;
    frame_a = 16'h0042;
    r0 = cyc;
    push(0, 32'hCAFE_F00D, 32'h0000_0042, r0 + 267);
    wait_to(r0 + 300);
    bus_a.i_enable = 1'b0;

    c2 = cyc;
    bus_b.i_duty = 32'hDEAD_BEEF;
    frame_b = 16'h0FFF;
    bus_b.i_enable = 1'b1;
    push(1, 32'hDEAD_BEEF, 32'hFFEF_F001, c2 + 267);
    push(1, 32'h0000_0007, 32'h7FFF_F800, c2 + 467);
    wait_to(c2 + 300);
    frame_b = 16'h0800;
    bus_b.i_duty = 32'h0000_0007;
    wait_to(c2 + 410);
    bus_b.i_enable = 1'b0;
    wait_to(c2 + 500);

    c3 = cyc;
    bus_c.i_duty = 32'h5555_5555;
    frame_c = 16'h0BAD;
    bus_c.i_enable = 1'b1;
    push(2, 32'h5555_5555, 32'h0000_0BAD, c3 + 427);
    push(2, 32'h0000_00AA, 32'h0000_0123, c3 + 827);
    wait_to(c3 + 399);
    chk("overrun_before_2nd_tick", 32'(bus_c.o_overrun), 0);
    wait_to(c3 + 405);
    chk("overrun_after_2nd_tick", 32'(bus_c.o_overrun), 1);
    wait_to(c3 + 430);
    bus_c.i_duty = 32'h0000_00AA;
    frame_c = 16'h0123;
    wait_to(c3 + 610);
    bus_c.i_enable = 1'b0;
    wait_to(c3 + 900);
    chk("overrun_sticky", 32'(bus_c.o_overrun), 1);
    chk("pending_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kf_meas_frontend.md
KF_MEAS_FRONTEND -- requirements
Module: kf_meas_frontend

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000: i_clk cycles per sample period, legal range 200..2^20.
REQ-002 Parameter SCLK_DIV, default 2: i_clk cycles per SCLK half-period, legal range 1..255.
REQ-003 Parameter GAIN, default 20'd1: unsigned Q-scale multiplier applied to the ADC code.
REQ-004 i_clk  in  1  system clock; the only clock.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_enable  in  1  1 = sample timer runs; 0 = timer held at 0, no new conversions.
REQ-007 i_duty  in  32  converter duty command, sampled as control input u.
REQ-008 i_adc_miso  in  1  serial data from the ADC.
REQ-009 o_adc_cs_n  out  1  ADC chip select, active-low.
REQ-010 o_adc_sclk  out  1  ADC serial clock, idle high.
REQ-011 o_u  out  32  latched duty; drives kalman_filter i_u.
REQ-012 o_y  out  32  scaled measurement; drives kalman_filter i_y.
REQ-013 o_begin  out  1  one-cycle strobe; drives kalman_filter i_begin.
REQ-014 o_overrun  out  1  sticky flag: a sample tick arrived while a conversion was busy.

Function
REQ-015 The sample timer shall count 0..SAMPLE_DIV-1 while i_enable=1, and a tick shall occur on the cycle it wraps to 0.
REQ-016 FSM states: IDLE, CONV, SCALE, DONE; reset state IDLE.
REQ-017 IDLE->CONV on a tick; o_adc_cs_n drops low and i_duty is captured into a holding register on the same edge.
REQ-018 CONV shall generate 16 SCLK periods: low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
REQ-019 i_adc_miso shall be shifted in MSB first on the i_clk edge where o_adc_sclk goes 0->1.
REQ-020 The frame is 4 leading zeros followed by a 12-bit code; leading bits shall be discarded.
REQ-021 After the 16th rising SCLK edge and its high half-period, o_adc_cs_n shall return high and the FSM shall go CONV->SCALE.
REQ-022 SCALE shall form y = code(12b unsigned) * GAIN(20b) as a 32-bit unsigned product with no truncation.
REQ-023 In SCALE the FSM shall load o_y with y and o_u with the holding register, then go to DONE.
REQ-024 DONE shall assert o_begin for exactly one cycle, then return to IDLE.
REQ-025 o_u and o_y shall change only in SCALE, so both are stable when o_begin is high.
REQ-026 Latency from tick to o_begin high shall be 1 + 32*SCLK_DIV + 2 cycles.
REQ-027 A tick in any state other than IDLE shall set o_overrun and be dropped; the conversion in progress shall continue.
REQ-028 o_overrun shall clear only on reset.
REQ-029 If i_enable falls mid-conversion, the conversion in progress shall complete and strobe normally.
REQ-030 While i_enable=0, the timer shall remain at 0; the first tick after re-enable shall occur SAMPLE_DIV cycles later.

Reset
REQ-031 On i_rst_n=0, immediately: FSM=IDLE, timer=0, o_adc_cs_n=1, o_adc_sclk=1, o_u=0, o_y=0, o_begin=0, o_overrun=0.
REQ-032 Reset asserted mid-conversion shall abort the frame with no o_begin; the first post-reset tick shall occur SAMPLE_DIV cycles after reset release with i_enable=1.

Structure
REQ-033 A shared package kf_pkg shall hold the data width (32), ADC frame length (16), code width (12) and the FSM state enum, for use by this block and kalman_filter.
REQ-034 One sub-module, adc_spi_rx, shall contain the SCLK generator, bit counter and shift register, with a start/done handshake; the timer, scaling and strobe logic stay in the top level.

Verification
REQ-035 SAMPLE_DIV=200, SCLK_DIV=2, GAIN=1, ADC model returns 0x0ABC, i_duty=32'h0000_8000 -> o_begin after 67 cycles; o_y=0x0ABC, o_u=0x8000.
REQ-036 GAIN=20'hFFFFF, code 0xFFF -> o_y=32'hFFEF_F001 (no overflow).
REQ-037 Hold i_enable=1 for 5 periods -> exactly 5 o_begin pulses, spaced 200 cycles apart; 80 SCLK rises; o_overrun=0.
REQ-038 SAMPLE_DIV=200, SCLK_DIV=7 (228-cycle conversion) -> o_overrun=1 after the second tick; the first result is still delivered correctly.
REQ-039 Pulse i_rst_n low at SCLK edge 8 -> o_adc_cs_n=1 and o_adc_sclk=1 immediately; no o_begin; outputs are 0.
REQ-040 Change i_duty during CONV -> o_u equals the value present at the tick, not the later value.
